debug_print_arbiter: RTL and testbench

//  Shares one debug character sink (log writer) among N requesters, e.g. the PEs of a tile

---
 rtl/debug_print_arbiter.sv | 173 +++++++++++++++++
 tb/tb_debug_print_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_print_arbiter.sv
// Round-robin line arbiter: N_REQ private line FIFOs feeding one character sink, whole lines only.
// Optional DEBUG_ARB_TAG_EN prefixes each line with "<hex grant>:".
module debug_print_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DEPTH = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_REQ-1:0]    req_en_i,
    input  logic [N_REQ-1:0]    req_we_i,
    input  logic [N_REQ*24-1:0] req_addr_i,
    input  logic [N_REQ*32-1:0] req_data_i,
    output logic [N_REQ-1:0]    req_ready_o,
    output logic                out_valid_o,
    output logic [7:0]          out_data_o,
    output logic [3:0]          out_src_o,
    input  logic                out_ready_i
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

`ifdef DEBUG_ARB_TAG_EN
    typedef enum logic [1:0] {StIdle, StTag, StDrain} state_t;
    logic r_tag_sel, w_tag_sel_d;
`else
    typedef enum logic {StIdle, StDrain} state_t;
`endif

    state_t          r_state, w_state_d;
    logic [IW-1:0]   r_grant, w_grant_d;
    logic [IW-1:0]   r_rr, w_rr_d;

    logic [N_REQ-1:0] w_push, w_full, w_elig, w_data_hi;
    logic [7:0]       w_head [N_REQ];
    logic [CW-1:0]    w_cnt  [N_REQ];
    logic             w_drain_pop, w_end, w_any;
    logic [IW-1:0]    w_pick;
    logic             w_unused_hi;

    assign w_drain_pop = (r_state == StDrain) & out_ready_i;
    assign req_ready_o = ~w_full;
    assign w_unused_hi = ^w_data_hi;

    for (genvar k = 0; k < N_REQ; k++) begin : g_buf
        logic [7:0]    r_mem [DEPTH];
        logic [PW-1:0] r_wptr, r_rptr;
        logic [CW-1:0] r_cnt, r_nl;
        logic          w_pop, w_push_nl, w_pop_nl;

        assign w_full[k]    = (r_cnt == CW'(DEPTH));
        assign w_push[k]    = req_en_i[k] & req_we_i[k] & (req_addr_i[24*k +: 24] == 24'h000000)
                              & ~w_full[k];
        assign w_pop        = w_drain_pop & (r_grant == IW'(k));
        assign w_elig[k]    = (r_nl != '0) | w_full[k];
        assign w_push_nl    = w_push[k] & (req_data_i[32*k +: 8] == 8'h0A);
        assign w_pop_nl     = w_pop & (r_mem[r_rptr] == 8'h0A);
        assign w_head[k]    = r_mem[r_rptr];
        assign w_cnt[k]     = r_cnt;
        assign w_data_hi[k] = ^req_data_i[32*k+8 +: 24];

        // Storage needs no reset: emptiness is tracked by r_cnt alone.
        always_ff @(posedge clk_i) begin
            if (w_push[k]) r_mem[r_wptr] <= req_data_i[32*k +: 8];
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
                r_nl   <= '0;
            end else begin
                if (w_push[k]) r_wptr <= r_wptr + PW'(1);
                if (w_pop)     r_rptr <= r_rptr + PW'(1);
                if (w_push[k] != w_pop) r_cnt <= w_push[k] ? r_cnt + CW'(1) : r_cnt - CW'(1);
                if (w_push_nl != w_pop_nl) r_nl <= w_push_nl ? r_nl + CW'(1) : r_nl - CW'(1);
            end
        end
    end

    // A line ends on '\n', or when a forced flush pops the last char with no refill.
    assign w_end = w_drain_pop & ((w_head[r_grant] == 8'h0A) |
                   ((w_cnt[r_grant] == CW'(1)) & ~w_push[r_grant]));

    // Scan downward so the eligible index closest to r_rr wins.
    always_comb begin
        int            j;
        logic [IW-1:0] idx;
        w_any  = 1'b0;
        w_pick = '0;
        j      = 0;
        idx    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = int'(r_rr) + i;
            if (j >= int'(N_REQ)) j = j - int'(N_REQ);
            idx = IW'(j);
            if (w_elig[idx]) begin
                w_any  = 1'b1;
                w_pick = idx;
            end
        end
    end

    always_comb begin
        logic [3:0] w_g4;
        w_state_d   = r_state;
        w_grant_d   = r_grant;
        w_rr_d      = r_rr;
        out_valid_o = 1'b0;
        out_data_o  = 8'h00;
        out_src_o   = 4'h0;
        w_g4        = 4'(r_grant);
`ifdef DEBUG_ARB_TAG_EN
        w_tag_sel_d = r_tag_sel;
`endif
        case (r_state)
            StIdle: begin
                if (w_any) begin
                    w_grant_d = w_pick;
`ifdef DEBUG_ARB_TAG_EN
                    w_state_d   = StTag;
                    w_tag_sel_d = 1'b0;
`else
                    w_state_d = StDrain;
`endif
                end
            end
`ifdef DEBUG_ARB_TAG_EN
            StTag: begin
                out_valid_o = 1'b1;
                out_src_o   = w_g4;
                if (r_tag_sel) out_data_o = 8'h3A;
                else out_data_o = (w_g4 < 4'd10) ? 8'h30 + {4'h0, w_g4} : 8'h37 + {4'h0, w_g4};
                if (out_ready_i) begin
                    if (r_tag_sel) w_state_d = StDrain;
                    w_tag_sel_d = 1'b1;
                end
            end
`endif
            StDrain: begin
                out_valid_o = 1'b1;
                out_src_o   = w_g4;
                out_data_o  = w_head[r_grant];
                if (w_end) begin
                    w_rr_d    = (r_grant == IW'(N_REQ - 1)) ? '0 : r_grant + IW'(1);
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= StIdle;
            r_grant   <= '0;
            r_rr      <= '0;
`ifdef DEBUG_ARB_TAG_EN
            r_tag_sel <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_d;
            r_grant   <= w_grant_d;
            r_rr      <= w_rr_d;
`ifdef DEBUG_ARB_TAG_EN
            r_tag_sel <= w_tag_sel_d;
`endif
        end
    end

endmodule

// File: tb/tb_debug_print_arbiter.sv
// Self-checking bench for debug_print_arbiter: directed scenarios plus randomized traffic
// checked against per-requester character queues and a line-level sink model.
module tb_debug_print_arbiter;

    localparam int N = 4;
    localparam int D = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   en = '0, we = '0;
    logic [N*24-1:0] addr = '0;
    logic [N*32-1:0] data = '0;
    logic           out_ready = 1'b0;
    logic [N-1:0]   w_ready;
    logic           w_valid;
    logic [7:0]     w_data;
    logic [3:0]     w_src;

    always #5 clk = ~clk;

    debug_print_arbiter #(.N_REQ(N), .DEPTH(D)) u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_en_i   (en),
        .req_we_i   (we),
        .req_addr_i (addr),
        .req_data_i (data),
        .req_ready_o(w_ready),
        .out_valid_o(w_valid),
        .out_data_o (w_data),
        .out_src_o  (w_src),
        .out_ready_i(out_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  q [N][$];
    logic [11:0] log_q[$];
    logic [11:0] exp_q[$];
    bit          line_act = 1'b0;
    int          cur_src  = 0;
    int          tpos     = 0;
    bit          s_valid  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input int v);
        return (v < 10) ? 8'(8'h30 + v) : 8'(8'h37 + v);
    endfunction

    task automatic clr_inputs();
        en = '0; we = '0; addr = '0; data = '0;
    endtask

    task automatic drive(input int k, input logic [7:0] ch, input logic [23:0] a);
        en[k] = 1'b1;
        we[k] = 1'b1;
        addr[24*k +: 24] = a;
        data[32*k +: 32] = {24'($urandom), ch};
    endtask

    task automatic clear_model();
        for (int k = 0; k < N; k++) q[k].delete();
        line_act = 1'b0;
        tpos = 0;
        log_q.delete();
        exp_q.delete();
    endtask

    // Sink side of the model: data integrity, tag prefix and no interleaving.
    task automatic sink_char(input logic [N-1:0] push);
        logic [7:0] c;
        log_q.push_back({w_src, w_data});
        if (!line_act) begin
            line_act = 1'b1;
            cur_src  = int'(w_src);
            tpos     = 0;
        end else begin
            check("no_interleave", 32'(w_src), 32'(cur_src));
        end
`ifdef DEBUG_ARB_TAG_EN
        if (tpos < 2) begin
            check("tag_char", 32'(w_data), 32'((tpos == 0) ? hexc(cur_src) : 8'h3A));
            tpos++;
        end else
`endif
        begin
            check("sb_nonempty", 32'(q[cur_src].size() != 0), 32'd1);
            if (q[cur_src].size() != 0) begin
                c = q[cur_src].pop_front();
                check("data", 32'(w_data), 32'(c));
                if (c == 8'h0A || (q[cur_src].size() == 0 && !push[cur_src])) line_act = 1'b0;
            end
        end
    endtask

    task automatic step();
        logic [N-1:0] exp_rdy;
        logic [N-1:0] push;
        @(negedge clk);
        for (int k = 0; k < N; k++) exp_rdy[k] = (q[k].size() < D);
        check("ready", 32'(w_ready), 32'(exp_rdy));
        for (int k = 0; k < N; k++)
            push[k] = en[k] & we[k] & (addr[24*k +: 24] == 24'h0) & exp_rdy[k];
        s_valid = w_valid;
        if (w_valid && out_ready) sink_char(push);
        for (int k = 0; k < N; k++)
            if (push[k]) q[k].push_back(data[32*k +: 8]);
        @(posedge clk);
        #1;
    endtask

    task automatic write_str(input int k, input string s, input logic [23:0] a);
        for (int i = 0; i < s.len(); i++) begin
            clr_inputs();
            drive(k, s[i], a);
            step();
        end
        clr_inputs();
    endtask

    task automatic write_str2(input int k0, input int k1, input string s);
        for (int i = 0; i < s.len(); i++) begin
            clr_inputs();
            drive(k0, s[i], 24'h0);
            drive(k1, s[i], 24'h0);
            step();
        end
        clr_inputs();
    endtask

    task automatic exp_line(input int k, input string s);
`ifdef DEBUG_ARB_TAG_EN
        exp_q.push_back({4'(k), hexc(k)});
        exp_q.push_back({4'(k), 8'h3A});
`endif
        for (int i = 0; i < s.len(); i++) exp_q.push_back({4'(k), 8'(s[i])});
    endtask

    task automatic compare_log(input string tag);
        int n;
        check({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s[%0d]", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic drain(input int max);
        int idle = 0;
        int n = 0;
        out_ready = 1'b1;
        while (idle < 4 && n < max) begin
            step();
            n++;
            idle = w_valid ? 0 : idle + 1;
        end
        check("drain_done", 32'(idle >= 4), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_inputs();
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(w_valid), 32'd0);
        check("rst_data", 32'(w_data), 32'd0);
        check("rst_src", 32'(w_src), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        check("rst_ready", 32'(w_ready), 32'hF);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        logic [7:0] held;
        logic [7:0] ch;
        string s;
        bit done;

        // Reset and a single line with its one-cycle bubble
        do_reset();
        out_ready = 1'b1;
        write_str(2, "hi\n", 24'h0);
        n = 0;
        s_valid = 1'b0;
        while (!s_valid && n < 10) begin
            step();
            n++;
        end
        check("first_char_latency", 32'(n), 32'd2);
        drain(50);
        exp_line(2, "hi\n");
        compare_log("hi_line");

        // Simultaneous lines, rr_ptr=0 then rr_ptr=1
        do_reset();
        write_str2(0, 1, "ab\n");
        drain(50);
        exp_line(0, "ab\n");
        exp_line(1, "ab\n");
        compare_log("rr0");
        do_reset();
        write_str(0, "x\n", 24'h0);
        drain(50);
        write_str2(0, 1, "ab\n");
        drain(50);
        exp_line(0, "x\n");
        exp_line(1, "ab\n");
        exp_line(0, "ab\n");
        compare_log("rr1");

        // Forced flush of a full buffer without '\n'
        do_reset();
        s = "";
        for (int i = 0; i < D; i++) begin
            ch = 8'(8'h61 + $urandom_range(0, 25));
            s = {s, string'(ch)};
        end
        for (int i = 0; i < D; i++) begin
            check("fill_ready3", 32'(w_ready[3]), 32'd1);
            clr_inputs();
            drive(3, s[i], 24'h0);
            step();
        end
        clr_inputs();
        step();
        check("full_ready3", 32'(w_ready[3]), 32'd0);
        drain(200);
        exp_line(3, s);
        compare_log("flush");
        check("ready3_after", 32'(w_ready[3]), 32'd1);

        // Ignored address, then a sink stall mid-line
        do_reset();
        out_ready = 1'b1;
        write_str(0, "no\n", 24'h000004);
        for (int i = 0; i < 5; i++) begin
            step();
            check("addr4_no_valid", 32'(w_valid), 32'd0);
        end
        out_ready = 1'b0;
        write_str(1, "stall__\n", 24'h0);
        n = 0;
        while (!w_valid && n < 10) begin
            step();
            n++;
        end
        check("stall_valid", 32'(w_valid), 32'd1);
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        held = w_data;
`ifdef DEBUG_ARB_TAG_EN
        check("stall_head", 32'(held), 32'h73);
`else
        check("stall_head", 32'(held), 32'h61);
`endif
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_data", 32'(w_data), 32'(held));
            check("stall_vld", 32'(w_valid), 32'd1);
        end
        drain(50);
        exp_line(1, "stall__\n");
        compare_log("stall");

        // Asynchronous reset mid-drain
        do_reset();
        out_ready = 1'b1;
        write_str(2, "abcdefghi\n", 24'h0);
        n = 0;
        while (log_q.size() < 3 && n < 20) begin
            step();
            n++;
        end
        check("mid_line_started", 32'(log_q.size() >= 3), 32'd1);
        #2 rst = 1'b1;
        #1 check("async_rst_valid", 32'(w_valid), 32'd0);
        repeat (2) @(posedge clk);
        clear_model();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (w_valid) seen++;
        end
        check("no_residual", 32'(seen), 32'd0);
        check("post_rst_ready", 32'(w_ready), 32'hF);

        // Randomized traffic
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            clr_inputs();
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 4) == 0) begin
                    ch = ($urandom_range(0, 9) == 0) ? 8'h0A : 8'(8'h61 + $urandom_range(0, 25));
                    drive(k, ch, ($urandom_range(0, 7) == 0) ? 24'h000004 : 24'h0);
                    if ($urandom_range(0, 9) == 0) we[k] = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        done = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            clr_inputs();
            for (int k = 0; k < N; k++)
                if (q[k].size() > 0 && q[k].size() < D && q[k][q[k].size()-1] != 8'h0A)
                    drive(k, 8'h0A, 24'h0);
            out_ready = 1'b1;
            step();
            if (!w_valid && !line_act && q[0].size() == 0 && q[1].size() == 0 &&
                q[2].size() == 0 && q[3].size() == 0) n++;
            else n = 0;
            done = (n >= 4);
        end
        check("rand_drained", 32'(done), 32'd1);
        for (int k = 0; k < N; k++) check($sformatf("rand_q%0d_empty", k), 32'(q[k].size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
